// File: rtl/soc_pkg.sv
// Shared SoC definitions for the peripheral bridge: bridge states, funct3 size/sign
// encodings, default peripheral window indices and access-legality helpers.
package soc_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  typedef enum logic [2:0] {
    FLAG_B  = 3'b000,
    FLAG_H  = 3'b001,
    FLAG_W  = 3'b010,
    FLAG_BU = 3'b100,
    FLAG_HU = 3'b101
  } mem_flag_e;

  localparam int unsigned WIN_UART  = 0;
  localparam int unsigned WIN_GPIO  = 1;
  localparam int unsigned WIN_TIMER = 2;
  localparam int unsigned WIN_PWM   = 3;

  function automatic logic flag_reserved(input logic [2:0] flag);
    logic res;
    case (flag)
      FLAG_B, FLAG_H, FLAG_W, FLAG_BU, FLAG_HU: res = 1'b0;
      default:                                  res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] flag, input logic [1:0] addr_lo);
    logic res;
    case (flag)
      FLAG_H, FLAG_HU: res = addr_lo[0];
      FLAG_W:          res = (addr_lo != 2'b00);
      default:         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/periph_lane_align.sv
// Combinational byte-lane helper: store data steering and byte enables, plus load
// byte/half extraction with sign or zero extension. Shared with mem_ctl.
module periph_lane_align
  import soc_pkg::*;
(
  input  logic [2:0]  flag,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [15:0] shifted_s;

  // Steer store data onto lanes and pull the addressed load lane down to bit 0
  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0000_0000;
    rdata_ext  = 32'h0000_0000;
    shifted_s  = 16'(rdata >> {addr_lo, 3'b000});
    case (flag)
      FLAG_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      FLAG_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {24'h00_0000, shifted_s[7:0]};
      end
      FLAG_H: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {{16{shifted_s[15]}}, shifted_s[15:0]};
      end
      FLAG_HU: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = {16'h0000, shifted_s[15:0]};
      end
      FLAG_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;
      end
      default: begin
        be         = 4'b0000;
        wdata_lane = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
      end
    endcase
  end

endmodule

// File: rtl/periph_bridge.sv
// Core data port to NUM_SLAVES memory-mapped peripherals: registered decode, ready
// handshake, lane steering and error responses. Define PERIPH_BRIDGE_TIMEOUT_EN for hung-slave abort.
module periph_bridge
  import soc_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int unsigned REGION_BITS    = 16,
  parameter int unsigned WINDOW_BITS    = 12,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic [2:0]               mem_flag,
  input  logic                     mem_we,
  input  logic                     mem_re,
  output logic [31:0]              mem_rdata,
  output logic                     mem_ready,
  output logic                     mem_error,
  output logic [NUM_SLAVES-1:0]    s_sel,
  output logic [WINDOW_BITS-1:0]   s_addr,
  output logic [31:0]              s_wdata,
  output logic [3:0]               s_be,
  output logic                     s_we,
  output logic                     s_re,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]    s_ready
);

  logic [1:0]             state_r;
  logic [2:0]             flag_r;
  logic [1:0]             addr_lo_r;
  logic                   mem_ready_r, mem_error_r;
  logic [31:0]            mem_rdata_r;
  logic [NUM_SLAVES-1:0]  s_sel_r;
  logic [WINDOW_BITS-1:0] s_addr_r;
  logic [31:0]            s_wdata_r;
  logic [3:0]             s_be_r;
  logic                   s_we_r, s_re_r;

  logic                   in_region_s, req_s, dec_err_s, slave_done_s, timeout_s;
  logic [3:0]             idx_s;
  logic [NUM_SLAVES-1:0]  sel_nxt_s;
  logic [2:0]             al_flag_s;
  logic [1:0]             al_lo_s;
  logic [3:0]             al_be_s;
  logic [31:0]            al_wdata_s, al_rdata_s, lane_rdata_s;

  assign idx_s = mem_addr[WINDOW_BITS +: 4];

  // Decode the incoming request and pick the selected slave's ready and read data
  always_comb begin
    in_region_s  = (mem_addr[31:REGION_BITS] == BASE_ADDR[31:REGION_BITS]);
    req_s        = (mem_we | mem_re) & in_region_s;
    dec_err_s    = ({1'b0, idx_s} >= 5'(NUM_SLAVES)) | flag_reserved(mem_flag)
                 | is_misaligned(mem_flag, mem_addr[1:0]);
    slave_done_s = |(s_ready & s_sel_r);
    sel_nxt_s    = {NUM_SLAVES{1'b0}};
    lane_rdata_s = 32'h0000_0000;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      sel_nxt_s[i] = (idx_s == 4'(i));
      lane_rdata_s = lane_rdata_s | (s_rdata[32*i +: 32] & {32{s_sel_r[i]}});
    end
    // The lane helper steers stores while idle and extracts loads while accessing
    if (state_r == ST_IDLE) begin
      al_flag_s = mem_flag;
      al_lo_s   = mem_addr[1:0];
    end else begin
      al_flag_s = flag_r;
      al_lo_s   = addr_lo_r;
    end
  end

  periph_lane_align u_align (
    .flag       (al_flag_s),
    .addr_lo    (al_lo_s),
    .wdata      (mem_wdata),
    .rdata      (lane_rdata_s),
    .be         (al_be_s),
    .wdata_lane (al_wdata_s),
    .rdata_ext  (al_rdata_s)
  );

`ifdef PERIPH_BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);
  logic [CNT_W-1:0] wait_cnt_r;

  assign timeout_s = (wait_cnt_r == CNT_W'(TIMEOUT_CYCLES)) & ~slave_done_s;

  // Count ACCESS cycles spent waiting on the selected slave
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_ACCESS) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (!slave_done_s && !timeout_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Bridge sequencer: accept or reject in IDLE, wait for the slave, then pulse the response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      flag_r      <= 3'b000;
      addr_lo_r   <= 2'b00;
      mem_ready_r <= 1'b0;
      mem_error_r <= 1'b0;
      mem_rdata_r <= 32'h0000_0000;
      s_sel_r     <= {NUM_SLAVES{1'b0}};
      s_addr_r    <= {WINDOW_BITS{1'b0}};
      s_wdata_r   <= 32'h0000_0000;
      s_be_r      <= 4'b0000;
      s_we_r      <= 1'b0;
      s_re_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mem_ready_r <= 1'b0;
          mem_error_r <= 1'b0;
          mem_rdata_r <= 32'h0000_0000;
          if (req_s) begin
            flag_r    <= mem_flag;
            addr_lo_r <= mem_addr[1:0];
            if (dec_err_s) begin
              state_r     <= ST_RESP;
              mem_ready_r <= 1'b1;
              mem_error_r <= 1'b1;
            end else begin
              state_r   <= ST_ACCESS;
              s_sel_r   <= sel_nxt_s;
              s_addr_r  <= {mem_addr[WINDOW_BITS-1:2], 2'b00};
              s_wdata_r <= mem_we ? al_wdata_s : 32'h0000_0000;
              s_be_r    <= al_be_s;
              s_we_r    <= mem_we;
              s_re_r    <= ~mem_we;
            end
          end
        end
        ST_ACCESS: begin
          if (slave_done_s || timeout_s) begin
            state_r     <= ST_RESP;
            mem_ready_r <= 1'b1;
            mem_error_r <= ~slave_done_s;
            mem_rdata_r <= (slave_done_s && !s_we_r) ? al_rdata_s : 32'h0000_0000;
            s_sel_r     <= {NUM_SLAVES{1'b0}};
            s_be_r      <= 4'b0000;
            s_we_r      <= 1'b0;
            s_re_r      <= 1'b0;
          end
        end
        ST_RESP: begin
          state_r     <= ST_IDLE;
          mem_ready_r <= 1'b0;
          mem_error_r <= 1'b0;
          mem_rdata_r <= 32'h0000_0000;
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_ready_r <= 1'b0;
          mem_error_r <= 1'b0;
          s_sel_r     <= {NUM_SLAVES{1'b0}};
          s_we_r      <= 1'b0;
          s_re_r      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_ready = mem_ready_r;
  assign mem_error = mem_error_r;
  assign mem_rdata = mem_rdata_r;
  assign s_sel     = s_sel_r;
  assign s_addr    = s_addr_r;
  assign s_wdata   = s_wdata_r;
  assign s_be      = s_be_r;
  assign s_we      = s_we_r;
  assign s_re      = s_re_r;

endmodule

// File: tb/tb_periph_bridge.sv
// Self-checking bench for periph_bridge: directed test-plan scenarios plus randomized
// accesses checked against a behavioural model of the address/lane/latency rules.
module tb_periph_bridge;
  localparam int NS = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata;
  logic [2:0]      mem_flag;
  logic            mem_we, mem_re, mem_ready, mem_error;
  logic [NS-1:0]   s_sel, s_ready;
  logic [11:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [3:0]      s_be;
  logic            s_we, s_re;
  logic [32*NS-1:0] s_rdata;

  int checks = 0;
  int fails  = 0;

  int            o_cyc;
  logic          o_err, o_swe, o_sre;
  logic [31:0]   o_rdata, o_wdata;
  logic [NS-1:0] o_sel, o_sel_resp;
  logic [3:0]    o_be;
  logic [11:0]   o_saddr;

  always #5 clk = ~clk;

  periph_bridge #(
    .NUM_SLAVES(NS), .BASE_ADDR(32'h4000_0000), .REGION_BITS(16),
    .WINDOW_BITS(12), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_flag(mem_flag), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_error(mem_error), .s_sel(s_sel), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_be(s_be), .s_we(s_we), .s_re(s_re),
    .s_rdata(s_rdata), .s_ready(s_ready)
  );

  // Drive one request from cycle 0 and play the addressed slave with wait_c wait cycles.
  task automatic run_access(input logic we, input logic re, input logic [31:0] addr,
                            input logic [2:0] flag, input logic [31:0] wd,
                            input int wait_c, input logic [31:0] sdata, input int budget);
    int cyc = 0;
    int sel_cnt = 0;
    o_cyc = 0; o_err = 1'b0; o_rdata = 32'h0; o_sel = '0; o_sel_resp = '0;
    o_be = 4'h0; o_wdata = 32'h0; o_saddr = 12'h0; o_swe = 1'b0; o_sre = 1'b0;
    mem_we = we; mem_re = re; mem_addr = addr; mem_flag = flag; mem_wdata = wd;
    s_ready = NS'($urandom);
    while (o_cyc == 0 && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_ready) begin
        o_cyc = cyc; o_err = mem_error; o_rdata = mem_rdata; o_sel_resp = s_sel;
        mem_we = 1'b0; mem_re = 1'b0;
      end else begin
        if (s_sel != '0) begin
          sel_cnt++;
          o_sel = s_sel; o_be = s_be; o_wdata = s_wdata; o_saddr = s_addr;
          o_swe = s_we; o_sre = s_re;
        end
        s_rdata = {$urandom, $urandom, $urandom, $urandom};
        s_ready = NS'($urandom) & ~s_sel;
        for (int i = 0; i < NS; i++) begin
          if (s_sel[i]) begin
            s_rdata[32*i +: 32] = sdata;
            s_ready[i] = (sel_cnt > wait_c);
          end
        end
      end
    end
    mem_we = 1'b0; mem_re = 1'b0; s_ready = '0;
    @(posedge clk); #1;
  endtask

  // Behavioural reference: legality, lanes, extension and latency from the address rules.
  task automatic model(input logic we, input logic [31:0] addr, input logic [2:0] flag,
                       input logic [31:0] wd, input int wait_c, input logic [31:0] sdata,
                       output int e_cyc, output logic e_err, output logic [31:0] e_rdata,
                       output logic [3:0] e_sel, output logic [3:0] e_be,
                       output logic [31:0] e_wdata);
    int idx = int'(addr[15:12]);
    int off = int'(addr % 4);
    int size;
    logic [31:0] mask, v;
    case (flag)
      3'd0, 3'd4: begin size = 1; mask = 32'h0000_00FF; end
      3'd1, 3'd5: begin size = 2; mask = 32'h0000_FFFF; end
      3'd2:       begin size = 4; mask = 32'hFFFF_FFFF; end
      default:    begin size = 0; mask = 32'h0; end
    endcase
    e_err = (size == 0) || (idx >= NS) || (size != 0 && (off % size) != 0);
    e_sel = e_err ? 4'h0 : 4'(1 << idx);
    e_be  = (size == 0) ? 4'h0 : 4'(((1 << size) - 1) << off);
    e_wdata = (size == 1) ? wd[7:0] * 32'h0101_0101 :
              (size == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    v = (sdata >> (8 * off)) & mask;
    if (flag[2] == 1'b0 && size < 4 && size > 0 && v[8*size-1]) v = v | ~mask;
    e_rdata = (e_err || we) ? 32'h0 : v;
    e_cyc = e_err ? 1 : wait_c + 2;
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    if (!e_err && wait_c > TO) begin
      e_cyc = TO + 2; e_err = 1'b1; e_rdata = 32'h0;
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_we = 1'b0; mem_re = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
    mem_flag = 3'b000; s_ready = '0; s_rdata = '0;
    #3;
    checks++;
    if ({mem_ready, mem_error, s_sel, s_we, s_re, s_be} !== 12'h000) begin
      fails++; $display("FAIL reset_ctrl: got %h expected 000", {mem_ready, mem_error, s_sel, s_we, s_re, s_be});
    end
    checks++;
    if ({mem_rdata, s_addr, s_wdata} !== 76'h0) begin
      fails++; $display("FAIL reset_data: got %h expected 0", {mem_rdata, s_addr, s_wdata});
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word_write();
    run_access(1'b1, 1'b0, 32'h4000_1000, 3'b010, 32'hDEAD_BEEF, 0, 32'h0, 20);
    checks++; if (o_sel !== 4'b0010) begin fails++; $display("FAIL sw_sel: got %b expected 0010", o_sel); end
    checks++; if (o_be !== 4'b1111) begin fails++; $display("FAIL sw_be: got %b expected 1111", o_be); end
    checks++; if (o_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_wdata: got %h expected deadbeef", o_wdata); end
    checks++; if (o_swe !== 1'b1 || o_sre !== 1'b0) begin fails++; $display("FAIL sw_strobe: got we=%b re=%b expected we=1 re=0", o_swe, o_sre); end
    checks++; if (o_cyc !== 2) begin fails++; $display("FAIL sw_latency: got %0d expected 2", o_cyc); end
    checks++; if (o_err !== 1'b0) begin fails++; $display("FAIL sw_error: got %b expected 0", o_err); end
  endtask

  task automatic test_byte_read();
    run_access(1'b0, 1'b1, 32'h4000_3003, 3'b000, 32'h0, 3, 32'h80FF_FFFF, 20);
    checks++; if (o_be !== 4'b1000) begin fails++; $display("FAIL lb_be: got %b expected 1000", o_be); end
    checks++; if (o_rdata !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_rdata: got %h expected ffffff80", o_rdata); end
    checks++; if (o_cyc !== 5) begin fails++; $display("FAIL lb_latency: got %0d expected 5", o_cyc); end
    run_access(1'b0, 1'b1, 32'h4000_3003, 3'b100, 32'h0, 3, 32'h80FF_FFFF, 20);
    checks++; if (o_rdata !== 32'h0000_0080) begin fails++; $display("FAIL lbu_rdata: got %h expected 00000080", o_rdata); end
    checks++; if (o_cyc !== 5) begin fails++; $display("FAIL lbu_latency: got %0d expected 5", o_cyc); end
  endtask

  task automatic test_half();
    run_access(1'b1, 1'b0, 32'h4000_0002, 3'b001, 32'h0000_1234, 0, 32'h0, 20);
    checks++; if (o_be !== 4'b1100) begin fails++; $display("FAIL sh_be: got %b expected 1100", o_be); end
    checks++; if (o_wdata !== 32'h1234_1234) begin fails++; $display("FAIL sh_wdata: got %h expected 12341234", o_wdata); end
    run_access(1'b0, 1'b1, 32'h4000_0001, 3'b001, 32'h0, 0, 32'h5555_AAAA, 20);
    checks++; if (o_err !== 1'b1 || o_cyc !== 1) begin fails++; $display("FAIL lh_misalign: got err=%b cyc=%0d expected err=1 cyc=1", o_err, o_cyc); end
    checks++; if (o_sel !== 4'b0000) begin fails++; $display("FAIL lh_nosel: got %b expected 0000", o_sel); end
  endtask

  task automatic test_decode_errors();
    run_access(1'b0, 1'b1, 32'h4000_5000, 3'b010, 32'h0, 0, 32'hFFFF_FFFF, 20);
    checks++; if (o_err !== 1'b1 || o_cyc !== 1 || o_rdata !== 32'h0) begin
      fails++; $display("FAIL unmapped: got err=%b cyc=%0d rdata=%h expected err=1 cyc=1 rdata=0", o_err, o_cyc, o_rdata);
    end
    run_access(1'b0, 1'b1, 32'h4000_2000, 3'b011, 32'h0, 0, 32'h0, 20);
    checks++; if (o_err !== 1'b1 || o_cyc !== 1 || o_sel !== 4'b0000) begin
      fails++; $display("FAIL reserved_flag: got err=%b cyc=%0d sel=%b expected err=1 cyc=1 sel=0000", o_err, o_cyc, o_sel);
    end
    run_access(1'b0, 1'b1, 32'h0100_0000, 3'b010, 32'h0, 0, 32'h0, 10);
    checks++; if (o_cyc !== 0 || o_sel !== 4'b0000) begin
      fails++; $display("FAIL out_of_region: got cyc=%0d sel=%b expected no response", o_cyc, o_sel);
    end
  endtask

  task automatic test_hung_slave();
`ifdef PERIPH_BRIDGE_TIMEOUT_EN
    run_access(1'b0, 1'b1, 32'h4000_0000, 3'b010, 32'h0, 1000, 32'h1234_5678, 40);
    checks++; if (o_cyc !== TO + 2 || o_err !== 1'b1 || o_rdata !== 32'h0) begin
      fails++; $display("FAIL timeout: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=1 rdata=0", o_cyc, o_err, o_rdata, TO + 2);
    end
    checks++; if (o_sel_resp !== 4'b0000) begin fails++; $display("FAIL timeout_sel: got %b expected 0000", o_sel_resp); end
    run_access(1'b0, 1'b1, 32'h4000_0000, 3'b010, 32'h0, TO, 32'h1234_5678, 40);
    checks++; if (o_cyc !== TO + 2 || o_err !== 1'b0 || o_rdata !== 32'h1234_5678) begin
      fails++; $display("FAIL ready_at_terminal: got cyc=%0d err=%b rdata=%h expected cyc=%0d err=0 rdata=12345678", o_cyc, o_err, o_rdata, TO + 2);
    end
    run_access(1'b0, 1'b1, 32'h4000_1004, 3'b010, 32'h0, 0, 32'hCAFE_F00D, 20);
    checks++; if (o_cyc !== 2 || o_err !== 1'b0 || o_rdata !== 32'hCAFE_F00D) begin
      fails++; $display("FAIL after_timeout: got cyc=%0d err=%b rdata=%h expected cyc=2 err=0 rdata=cafef00d", o_cyc, o_err, o_rdata);
    end
`else
    run_access(1'b0, 1'b1, 32'h4000_0000, 3'b010, 32'h0, 30, 32'h1234_5678, 60);
    checks++; if (o_cyc !== 32 || o_err !== 1'b0 || o_rdata !== 32'h1234_5678) begin
      fails++; $display("FAIL long_wait: got cyc=%0d err=%b rdata=%h expected cyc=32 err=0 rdata=12345678", o_cyc, o_err, o_rdata);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    mem_we = 1'b0; mem_re = 1'b1; mem_addr = 32'h4000_2004; mem_flag = 3'b010;
    s_ready = '0; s_rdata = '0; s_rdata[64 +: 32] = 32'hA5A5_0F0F;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      exp_rdy = (c == 2 || c == 5);
      checks++;
      if (mem_ready !== exp_rdy) begin fails++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, mem_ready, exp_rdy); end
      if (exp_rdy) begin
        checks++;
        if (mem_rdata !== 32'hA5A5_0F0F) begin fails++; $display("FAIL b2b_rdata c%0d: got %h expected a5a50f0f", c, mem_rdata); end
      end
      s_ready = s_sel;
    end
    mem_re = 1'b0; s_ready = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_access();
    mem_we = 1'b0; mem_re = 1'b1; mem_addr = 32'h4000_2008; mem_flag = 3'b010; s_ready = '0;
    repeat (3) begin @(posedge clk); #1; s_ready = '0; end
    checks++; if (s_sel !== 4'b0100) begin fails++; $display("FAIL mid_sel: got %b expected 0100", s_sel); end
    #2 rst_n = 1'b0; #1;
    checks++;
    if ({mem_ready, mem_error, s_sel, s_we, s_re, s_be, mem_rdata, s_addr, s_wdata} !== 88'h0) begin
      fails++; $display("FAIL mid_reset: got sel=%b ready=%b be=%b expected all zero", s_sel, mem_ready, s_be);
    end
    mem_re = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checks++; if (mem_ready !== 1'b0) begin fails++; $display("FAIL mid_noresp: got %b expected 0", mem_ready); end
    end
    run_access(1'b0, 1'b1, 32'h4000_2008, 3'b010, 32'h0, 1, 32'h0BAD_CAFE, 20);
    checks++; if (o_cyc !== 3 || o_err !== 1'b0 || o_rdata !== 32'h0BAD_CAFE) begin
      fails++; $display("FAIL post_reset: got cyc=%0d err=%b rdata=%h expected cyc=3 err=0 rdata=0badcafe", o_cyc, o_err, o_rdata);
    end
  endtask

  task automatic test_random();
    logic        we, re, e_err;
    logic [2:0]  flag;
    logic [31:0] addr, wd, sd, e_rdata, e_wdata;
    logic [3:0]  e_sel, e_be;
    int          wait_c, e_cyc;
    for (int n = 0; n < 40; n++) begin
      addr = 32'h4000_0000 + 32'($urandom_range(0, 5)) * 32'h1000 + 32'($urandom_range(0, 4095));
      flag = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      re = we ? 1'($urandom_range(0, 1)) : 1'b1;
      wd = $urandom; sd = $urandom; wait_c = $urandom_range(0, 3);
      model(we, addr, flag, wd, wait_c, sd, e_cyc, e_err, e_rdata, e_sel, e_be, e_wdata);
      run_access(we, re, addr, flag, wd, wait_c, sd, 20);
      checks++;
      if (o_cyc !== e_cyc || o_err !== e_err || o_rdata !== e_rdata) begin
        fails++; $display("FAIL rnd_resp a=%h f=%b we=%b: got cyc=%0d err=%b rd=%h expected cyc=%0d err=%b rd=%h",
                          addr, flag, we, o_cyc, o_err, o_rdata, e_cyc, e_err, e_rdata);
      end
      checks++;
      if (o_sel !== e_sel || o_sel_resp !== 4'b0000) begin
        fails++; $display("FAIL rnd_sel a=%h: got sel=%b resp_sel=%b expected sel=%b resp_sel=0000", addr, o_sel, o_sel_resp, e_sel);
      end
      if (!e_err) begin
        checks++;
        if (o_be !== e_be || o_saddr !== {addr[11:2], 2'b00} || o_swe !== we || o_sre !== !we) begin
          fails++; $display("FAIL rnd_strobe a=%h: got be=%b sa=%h we=%b re=%b expected be=%b sa=%h we=%b",
                            addr, o_be, o_saddr, o_swe, o_sre, e_be, {addr[11:2], 2'b00}, we);
        end
        if (we) begin
          checks++;
          if (o_wdata !== e_wdata) begin fails++; $display("FAIL rnd_wdata a=%h: got %h expected %h", addr, o_wdata, e_wdata); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word_write();
    test_byte_read();
    test_half();
    test_decode_errors();
    test_hung_slave();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
